// File: rtl/mc_datapath_pkg.sv
// Shared definitions for the multi-cycle datapath: opcode map, FSM states,
// ALU function codes and opcode classification helpers.
package mc_datapath_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned FN_W    = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 6'h00;
  localparam logic [OP_W-1:0] OP_SUB  = 6'h01;
  localparam logic [OP_W-1:0] OP_AND  = 6'h02;
  localparam logic [OP_W-1:0] OP_NOR  = 6'h03;
  localparam logic [OP_W-1:0] OP_OR   = 6'h04;
  localparam logic [OP_W-1:0] OP_SLT  = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h06;
  localparam logic [OP_W-1:0] OP_SUBI = 6'h07;
  localparam logic [OP_W-1:0] OP_ANDI = 6'h08;
  localparam logic [OP_W-1:0] OP_ORI  = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI = 6'h0A;
  localparam logic [OP_W-1:0] OP_LW   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_SW   = 6'h12;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'h13;
  localparam logic [OP_W-1:0] OP_BNEQ = 6'h14;
  localparam logic [OP_W-1:0] OP_BGEZ = 6'h15;
  localparam logic [OP_W-1:0] OP_J    = 6'h16;
  localparam logic [OP_W-1:0] OP_JAL  = 6'h17;
  localparam logic [OP_W-1:0] OP_JR   = 6'h18;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_e;

  typedef enum logic [FN_W-1:0] {
    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_PASS
  } alu_fn_e;

  // Opcodes the core implements; anything else traps.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_NOR, OP_OR, OP_SLT, OP_ADDI, OP_SUBI,
      OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_LUI, OP_SW, OP_BEQ, OP_BNEQ,
      OP_BGEZ, OP_J, OP_JAL, OP_JR: op_legal = 1'b1;
      default:                      op_legal = 1'b0;
    endcase
  endfunction

  // Register-register ops write rd; immediate ops write rt.
  function automatic logic op_is_rtype(input logic [OP_W-1:0] op);
    op_is_rtype = (op <= OP_SLT);
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU.
//   fn    : ALU function (alu_fn_e encoding)
//   a, b  : operands
//   y_c   : result
//   ovf_c : signed overflow, meaningful for add/sub only
module mc_alu
  import mc_datapath_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [FN_W-1:0] fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y_c,
  output logic            ovf_c
);

  localparam int unsigned MSB = XLEN - 1;

  logic [XLEN-1:0] sum_c;
  logic [XLEN-1:0] diff_c;
  logic            lt_c;

  assign sum_c  = a + b;
  assign diff_c = a - b;
  assign lt_c   = $signed(a) < $signed(b);

  // Function select; overflow when the result sign contradicts the operand signs.
  always_comb begin
    y_c   = '0;
    ovf_c = 1'b0;
    case (alu_fn_e'(fn))
      FN_ADD: begin
        y_c   = sum_c;
        ovf_c = (a[MSB] == b[MSB]) && (sum_c[MSB] != a[MSB]);
      end
      FN_SUB: begin
        y_c   = diff_c;
        ovf_c = (a[MSB] != b[MSB]) && (diff_c[MSB] != a[MSB]);
      end
      FN_AND:  y_c = a & b;
      FN_OR:   y_c = a | b;
      FN_NOR:  y_c = ~(a | b);
      FN_SLT:  y_c = XLEN'(lt_c);
      default: y_c = b;
    endcase
  end

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle datapath: FETCH/DECODE/EXEC/MEM/WB FSM with internal register
// file, instruction- and data-memory request/ack handshakes and a sticky trap.
//   imem_req/addr/rdata/ack : instruction fetch handshake (addr = pc)
//   dmem_req/we/addr/wdata/rdata/ack : load/store handshake
//   result   : last value written to the register file
//   pc       : program counter
//   overflow : signed overflow of the last retired add/sub/addi/subi
//   retire   : one-cycle pulse per completed instruction
//   trap     : sticky halt on illegal opcode or misaligned access
module multicycle_datapath
  import mc_datapath_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned PC_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [PC_W-1:0]    dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic               dmem_ack,
  output logic [XLEN-1:0]    result,
  output logic [PC_W-1:0]    pc,
  output logic               overflow,
  output logic               retire,
  output logic               trap
);

  localparam int unsigned RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]      a_q, a_d, b_q, b_d, ex_q, ex_d;
  logic                 ovf_ex_q, ovf_ex_d;
  logic [XLEN-1:0]      rf [NREGS];

  logic                 imem_req_d, dmem_req_d, dmem_we_d;
  logic [PC_W-1:0]      pc_d, dmem_addr_d;
  logic [XLEN-1:0]      dmem_wdata_d, result_d;
  logic                 overflow_d, retire_d, trap_d;

  logic                 rf_we_c;
  logic [RIDX_W-1:0]    rf_waddr_c;
  logic [XLEN-1:0]      rf_wdata_c;

  // Instruction fields.
  logic [OP_W-1:0]      op_c;
  logic [RIDX_W-1:0]    rs_c, rt_c, rd_c, dest_c;
  logic [15:0]          imm_c;
  logic [XLEN-1:0]      simm_c, zimm_c, lui_c;
  logic [31:0]          simm32_c, pc32_c, jtgt32_c;
  logic [PC_W-1:0]      br_tgt_c, j_tgt_c;
  logic                 is_arith_c, br_taken_c;

  alu_fn_e              alu_fn_c;
  logic [XLEN-1:0]      alu_b_c, alu_y_c;
  logic                 alu_ovf_c;

  assign op_c     = instr_q[31:26];
  assign rs_c     = instr_q[21 +: RIDX_W];
  assign rt_c     = instr_q[16 +: RIDX_W];
  assign rd_c     = instr_q[11 +: RIDX_W];
  assign imm_c    = instr_q[15:0];
  assign simm_c   = XLEN'($signed(imm_c));
  assign zimm_c   = XLEN'(imm_c);
  assign lui_c    = XLEN'({imm_c, 16'h0000});
  assign simm32_c = 32'($signed(imm_c));
  assign pc32_c   = 32'(pc);
  assign imem_addr = pc;

  // pc already holds pc+4 of the executing instruction.
  assign br_tgt_c = pc + PC_W'(simm32_c << 2);
  assign jtgt32_c = (pc32_c & 32'hF000_0000) | {4'h0, instr_q[25:0], 2'b00};
  assign j_tgt_c  = PC_W'(jtgt32_c);

  assign is_arith_c = (op_c == OP_ADD) || (op_c == OP_SUB) ||
                      (op_c == OP_ADDI) || (op_c == OP_SUBI);
  assign dest_c = (op_c == OP_JAL)   ? RIDX_W'(NREGS - 1) :
                  op_is_rtype(op_c)  ? rd_c : rt_c;

  always_comb begin
    case (op_c)
      OP_BEQ:  br_taken_c = (a_q == b_q);
      OP_BNEQ: br_taken_c = (a_q != b_q);
      OP_BGEZ: br_taken_c = !a_q[XLEN-1];
      default: br_taken_c = 1'b0;
    endcase
  end

  // ALU function and second operand per opcode.
  always_comb begin
    alu_fn_c = FN_PASS;
    alu_b_c  = b_q;
    case (op_c)
      OP_ADD:         alu_fn_c = FN_ADD;
      OP_SUB:         alu_fn_c = FN_SUB;
      OP_AND:         alu_fn_c = FN_AND;
      OP_NOR:         alu_fn_c = FN_NOR;
      OP_OR:          alu_fn_c = FN_OR;
      OP_SLT:         alu_fn_c = FN_SLT;
      OP_ADDI, OP_LW,
      OP_SW:          begin alu_fn_c = FN_ADD; alu_b_c = simm_c; end
      OP_SUBI:        begin alu_fn_c = FN_SUB; alu_b_c = simm_c; end
      OP_ANDI:        begin alu_fn_c = FN_AND; alu_b_c = zimm_c; end
      OP_ORI:         begin alu_fn_c = FN_OR;  alu_b_c = zimm_c; end
      OP_SLTI:        begin alu_fn_c = FN_SLT; alu_b_c = simm_c; end
      OP_LUI:         alu_b_c = lui_c;
      default:        ;
    endcase
  end

  mc_alu #(.XLEN(XLEN)) u_alu (
    .fn    (alu_fn_c),
    .a     (a_q),
    .b     (alu_b_c),
    .y_c   (alu_y_c),
    .ovf_c (alu_ovf_c)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    a_d          = a_q;
    b_d          = b_q;
    ex_d         = ex_q;
    ovf_ex_d     = ovf_ex_q;
    pc_d         = pc;
    imem_req_d   = imem_req;
    dmem_req_d   = dmem_req;
    dmem_we_d    = dmem_we;
    dmem_addr_d  = dmem_addr;
    dmem_wdata_d = dmem_wdata;
    result_d     = result;
    overflow_d   = overflow;
    retire_d     = 1'b0;
    trap_d       = trap;
    rf_we_c      = 1'b0;
    rf_waddr_c   = '0;
    rf_wdata_c   = '0;

    case (state_q)
      ST_FETCH: begin
        // Request is raised on entry; after reset it starts one cycle late.
        if (!imem_req) begin
          imem_req_d = 1'b1;
        end else if (imem_ack) begin
          instr_d    = imem_rdata;
          pc_d       = pc + PC_W'(4);
          imem_req_d = 1'b0;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!op_legal(op_c)) begin
          trap_d  = 1'b1;
          state_d = ST_TRAP;
        end else begin
          a_d     = rf[rs_c];
          b_d     = rf[rt_c];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_c)
          OP_LW, OP_SW: begin
            if (alu_y_c[1:0] != 2'b00) begin
              trap_d  = 1'b1;
              state_d = ST_TRAP;
            end else begin
              dmem_req_d   = 1'b1;
              dmem_we_d    = (op_c == OP_SW);
              dmem_addr_d  = PC_W'(alu_y_c);
              dmem_wdata_d = b_q;
              state_d      = ST_MEM;
            end
          end
          OP_BEQ, OP_BNEQ, OP_BGEZ, OP_J, OP_JR: begin
            if (op_c == OP_J)       pc_d = j_tgt_c;
            else if (op_c == OP_JR) pc_d = PC_W'(a_q);
            else if (br_taken_c)    pc_d = br_tgt_c;
            retire_d   = 1'b1;
            overflow_d = 1'b0;
            imem_req_d = 1'b1;
            state_d    = ST_FETCH;
          end
          OP_JAL: begin
            ex_d     = XLEN'(pc);
            ovf_ex_d = 1'b0;
            pc_d     = j_tgt_c;
            state_d  = ST_WB;
          end
          default: begin
            ex_d     = alu_y_c;
            ovf_ex_d = is_arith_c && alu_ovf_c;
            state_d  = ST_WB;
          end
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (dmem_we) begin
            retire_d   = 1'b1;
            overflow_d = 1'b0;
            imem_req_d = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            ex_d     = dmem_rdata;
            ovf_ex_d = 1'b0;
            state_d  = ST_WB;
          end
        end
      end
      ST_WB: begin
        // r0 stays zero; result still reports the discarded value.
        rf_we_c    = (dest_c != '0);
        rf_waddr_c = dest_c;
        rf_wdata_c = ex_q;
        result_d   = ex_q;
        overflow_d = ovf_ex_q;
        retire_d   = 1'b1;
        imem_req_d = 1'b1;
        state_d    = ST_FETCH;
      end
      default: begin
        imem_req_d = 1'b0;
        dmem_req_d = 1'b0;
        state_d    = ST_TRAP;
      end
    endcase
  end

  // State, outputs and register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      instr_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ex_q       <= '0;
      ovf_ex_q   <= 1'b0;
      pc         <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      result     <= '0;
      overflow   <= 1'b0;
      retire     <= 1'b0;
      trap       <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ex_q       <= ex_d;
      ovf_ex_q   <= ovf_ex_d;
      pc         <= pc_d;
      imem_req   <= imem_req_d;
      dmem_req   <= dmem_req_d;
      dmem_we    <= dmem_we_d;
      dmem_addr  <= dmem_addr_d;
      dmem_wdata <= dmem_wdata_d;
      result     <= result_d;
      overflow   <= overflow_d;
      retire     <= retire_d;
      trap       <= trap_d;
      if (rf_we_c) rf[rf_waddr_c] <= rf_wdata_c;
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath with request/ack memory models.
module tb_multicycle_datapath;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned PC_W  = 8;

  localparam logic [5:0] OP_ADD = 6'h00, OP_AND = 6'h02, OP_SLT = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h06, OP_SUBI = 6'h07, OP_ANDI = 6'h08;
  localparam logic [5:0] OP_ORI = 6'h09, OP_SLTI = 6'h0A, OP_LW = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0E, OP_SW = 6'h12, OP_BEQ = 6'h13;
  localparam logic [5:0] OP_BNEQ = 6'h14, OP_J = 6'h16, OP_JAL = 6'h17;

  logic            clk, rst_n;
  logic            imem_req, imem_ack;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            dmem_req, dmem_we, dmem_ack;
  logic [PC_W-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata, dmem_rdata, result;
  logic [PC_W-1:0] pc;
  logic            overflow, retire, trap;

  logic [31:0]     imem [64];
  logic [31:0]     dmem [64];
  int              i_delay, d_delay, i_cnt, d_cnt, ireq_cnt, dreq_cnt;
  int              n_checks, n_fail;

  multicycle_datapath #(.XLEN(XLEN), .NREGS(NREGS), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .result(result), .pc(pc), .overflow(overflow), .retire(retire), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: ack after a programmable number of wait cycles.
  assign imem_ack   = imem_req && (i_cnt >= i_delay);
  assign imem_rdata = imem[imem_addr[7:2]];
  assign dmem_ack   = dmem_req && (d_cnt >= d_delay);
  assign dmem_rdata = dmem[dmem_addr[7:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_cnt <= 0;
      d_cnt <= 0;
    end else begin
      i_cnt <= (imem_req && !imem_ack) ? i_cnt + 1 : 0;
      d_cnt <= (dmem_req && !dmem_ack) ? d_cnt + 1 : 0;
    end
  end

  always @(posedge clk) begin
    if (imem_req) ireq_cnt <= ireq_cnt + 1;
    if (dmem_req) dreq_cnt <= dreq_cnt + 1;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
  end

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'h000};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Cycles until the next retire pulse, -1 on timeout.
  task automatic wait_retire(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!retire && n < 100);
    if (!retire) n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_delay = 0; d_delay = 0;
    clear_imem();
    @(negedge clk);
    n_checks++;
    if ({imem_req, dmem_req, dmem_we, retire, trap, overflow} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000", {imem_req, dmem_req, dmem_we, retire, trap, overflow});
    end
    n_checks++;
    if (pc !== 8'h00 || imem_addr !== 8'h00 || result !== 32'h0) begin
      n_fail++; $display("FAIL reset_values: pc %h addr %h result %h want all 0", pc, imem_addr, result);
    end
  endtask

  task automatic test_reset_mid_mem();
    clear_imem();
    imem[0] = enc_i(OP_SW, 0, 0, 16'h0010);
    d_delay = 50;
    do_reset();
    for (int k = 0; k < 20 && !dmem_req; k++) @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 8'h10) begin
      n_fail++; $display("FAIL mid_mem_req: req %b we %b addr %h want 1 1 10", dmem_req, dmem_we, dmem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, dmem_req, dmem_we, retire, trap, overflow} !== 6'b0 || pc !== 8'h00 ||
        dmem_addr !== 8'h00 || result !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: req %b dreq %b pc %h daddr %h want zeros", imem_req, dmem_req, pc, dmem_addr);
    end
    d_delay = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL release_no_req: got %b want 0", imem_req);
    end
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      n_fail++; $display("FAIL first_fetch: req %b addr %h want 1 00", imem_req, imem_addr);
    end
  endtask

  task automatic test_alu_overflow();
    logic [31:0] exp_res [9];
    logic        exp_ovf [9];
    int          exp_lat [9];
    int          n;
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 0, 1, 16'hFFFF);    exp_res[0] = 32'hFFFF_FFFF; exp_ovf[0] = 0; exp_lat[0] = 5;
    imem[1] = enc_r(OP_ADD, 1, 1, 2);            exp_res[1] = 32'hFFFF_FFFE; exp_ovf[1] = 0; exp_lat[1] = 4;
    imem[2] = enc_i(OP_LUI, 0, 3, 16'h7FFF);     exp_res[2] = 32'h7FFF_0000; exp_ovf[2] = 0; exp_lat[2] = 4;
    imem[3] = enc_i(OP_ORI, 3, 3, 16'hFFFF);     exp_res[3] = 32'h7FFF_FFFF; exp_ovf[3] = 0; exp_lat[3] = 4;
    imem[4] = enc_i(OP_ADDI, 3, 4, 16'h0001);    exp_res[4] = 32'h8000_0000; exp_ovf[4] = 1; exp_lat[4] = 4;
    imem[5] = enc_r(OP_SLT, 1, 0, 5);            exp_res[5] = 32'h0000_0001; exp_ovf[5] = 0; exp_lat[5] = 4;
    imem[6] = enc_i(OP_SUBI, 4, 6, 16'h0001);    exp_res[6] = 32'h7FFF_FFFF; exp_ovf[6] = 1; exp_lat[6] = 4;
    imem[7] = enc_i(OP_ANDI, 1, 7, 16'h8001);    exp_res[7] = 32'h0000_8001; exp_ovf[7] = 0; exp_lat[7] = 4;
    imem[8] = enc_i(OP_SLTI, 3, 8, 16'hFFFF);    exp_res[8] = 32'h0000_0000; exp_ovf[8] = 0; exp_lat[8] = 4;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      wait_retire(n);
      n_checks++;
      if (n !== exp_lat[i]) begin
        n_fail++; $display("FAIL alu_lat[%0d]: got %0d want %0d", i, n, exp_lat[i]);
      end
      n_checks++;
      if (result !== exp_res[i]) begin
        n_fail++; $display("FAIL alu_result[%0d]: got %h want %h", i, result, exp_res[i]);
      end
      n_checks++;
      if (overflow !== exp_ovf[i]) begin
        n_fail++; $display("FAIL alu_ovf[%0d]: got %b want %b", i, overflow, exp_ovf[i]);
      end
    end
  endtask

  task automatic test_mem();
    int n, d0;
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 0, 1, 16'h5A5A);
    imem[1] = enc_i(OP_SW, 0, 1, 16'h0010);
    imem[2] = enc_i(OP_LW, 0, 5, 16'h0010);
    imem[3] = enc_r(OP_ADD, 5, 5, 6);
    d_delay = 3;
    do_reset();
    wait_retire(n);
    d0 = dreq_cnt;
    wait_retire(n);
    n_checks++;
    if (n !== 7) begin n_fail++; $display("FAIL sw_lat: got %0d want 7", n); end
    n_checks++;
    if (dreq_cnt - d0 !== 4) begin n_fail++; $display("FAIL sw_req_cycles: got %0d want 4", dreq_cnt - d0); end
    n_checks++;
    if (dmem[4] !== 32'h0000_5A5A) begin n_fail++; $display("FAIL sw_data: got %h want 00005a5a", dmem[4]); end
    d0 = dreq_cnt;
    wait_retire(n);
    n_checks++;
    if (n !== 8) begin n_fail++; $display("FAIL lw_lat: got %0d want 8", n); end
    n_checks++;
    if (dreq_cnt - d0 !== 4) begin n_fail++; $display("FAIL lw_req_cycles: got %0d want 4", dreq_cnt - d0); end
    n_checks++;
    if (result !== 32'h0000_5A5A) begin n_fail++; $display("FAIL lw_result: got %h want 00005a5a", result); end
    wait_retire(n);
    n_checks++;
    if (result !== 32'h0000_B4B4 || n !== 4) begin
      n_fail++; $display("FAIL lw_use: result %h lat %0d want 0000b4b4 4", result, n);
    end
    d_delay = 0;
  endtask

  task automatic test_branch_jump();
    int n;
    clear_imem();
    imem[0] = enc_j(OP_J, 26'd8);
    imem[8] = enc_i(OP_BEQ, 0, 0, 16'hFFFE);
    imem[7] = enc_j(OP_JAL, 26'd5);
    imem[5] = enc_i(OP_SW, 0, 31, 16'h0010);
    imem[6] = enc_i(OP_BNEQ, 0, 0, 16'h0005);
    do_reset();
    wait_retire(n);
    n_checks++;
    if (pc !== 8'h20 || n !== 4) begin n_fail++; $display("FAIL j_pc: pc %h lat %0d want 20 4", pc, n); end
    wait_retire(n);
    n_checks++;
    if (pc !== 8'h1C || n !== 3) begin n_fail++; $display("FAIL beq_taken: pc %h lat %0d want 1c 3", pc, n); end
    wait_retire(n);
    n_checks++;
    if (pc !== 8'h14 || n !== 4) begin n_fail++; $display("FAIL jal_pc: pc %h lat %0d want 14 4", pc, n); end
    n_checks++;
    if (result !== 32'h0000_0020) begin n_fail++; $display("FAIL jal_link: got %h want 00000020", result); end
    wait_retire(n);
    n_checks++;
    if (dmem[4] !== 32'h0000_0020) begin n_fail++; $display("FAIL jal_r31: got %h want 00000020", dmem[4]); end
    wait_retire(n);
    n_checks++;
    if (pc !== 8'h1C || n !== 3) begin n_fail++; $display("FAIL bneq_not_taken: pc %h lat %0d want 1c 3", pc, n); end
  endtask

  task automatic test_trap();
    int n, i0, d0;
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 0, 1, 16'h0011);
    imem[1] = enc_i(OP_LW, 1, 2, 16'h0000);
    do_reset();
    wait_retire(n);
    for (int k = 0; k < 20 && !trap; k++) @(negedge clk);
    n_checks++;
    if (trap !== 1'b1 || pc !== 8'h08) begin n_fail++; $display("FAIL misalign_trap: trap %b pc %h want 1 08", trap, pc); end
    i0 = ireq_cnt; d0 = dreq_cnt;
    repeat (10) @(negedge clk);
    n_checks++;
    if (ireq_cnt - i0 !== 0 || dreq_cnt - d0 !== 0 || trap !== 1'b1 || pc !== 8'h08) begin
      n_fail++; $display("FAIL trap_halt: ireq %0d dreq %0d trap %b pc %h want 0 0 1 08", ireq_cnt - i0, dreq_cnt - d0, trap, pc);
    end
    clear_imem();
    imem[0] = 32'hFC00_0000;
    do_reset();
    for (int k = 0; k < 20 && !trap; k++) @(negedge clk);
    n_checks++;
    if (trap !== 1'b1 || pc !== 8'h04 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL illegal_trap: trap %b pc %h req %b want 1 04 0", trap, pc, imem_req);
    end
  endtask

  task automatic test_r0_wrap();
    int n;
    clear_imem();
    imem[0]  = enc_i(OP_ADDI, 0, 0, 16'h0005);
    imem[1]  = enc_r(OP_ADD, 0, 0, 1);
    imem[2]  = enc_j(OP_J, 26'd63);
    imem[63] = enc_i(OP_ADDI, 0, 2, 16'h0007);
    do_reset();
    wait_retire(n);
    n_checks++;
    if (result !== 32'h5) begin n_fail++; $display("FAIL r0_result: got %h want 00000005", result); end
    wait_retire(n);
    n_checks++;
    if (result !== 32'h0) begin n_fail++; $display("FAIL r0_reads_zero: got %h want 00000000", result); end
    wait_retire(n);
    n_checks++;
    if (pc !== 8'hFC) begin n_fail++; $display("FAIL j_fc: got %h want fc", pc); end
    wait_retire(n);
    n_checks++;
    if (pc !== 8'h00 || imem_addr !== 8'h00 || result !== 32'h7) begin
      n_fail++; $display("FAIL pc_wrap: pc %h addr %h result %h want 00 00 00000007", pc, imem_addr, result);
    end
    wait_retire(n);
    n_checks++;
    if (result !== 32'h5 || n !== 4) begin n_fail++; $display("FAIL after_wrap: result %h lat %0d want 00000005 4", result, n); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_reset_mid_mem();
    test_alu_overflow();
    test_mem();
    test_branch_jump();
    test_trap();
    test_r0_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
